// File: rtl/raster_to_tile_converter.sv
// Raster-to-tile reorder: two ping-pong strip buffers, each TILE_WIDTH rows deep, let one strip
// fill while the other drains as row-major TILE_WIDTH x TILE_WIDTH tiles.
module raster_to_tile_converter #(
  parameter int unsigned TILE_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oTileStart,
  output logic       oTileLast,
  output logic       oFrameLast
);

  localparam int unsigned Depth     = IMAGE_WIDTH * TILE_WIDTH;
  localparam int unsigned AW        = $clog2(Depth);
  localparam int unsigned XW        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned TW        = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
  localparam int unsigned NumTiles  = IMAGE_WIDTH / TILE_WIDTH;
  localparam int unsigned NW        = (NumTiles > 1) ? $clog2(NumTiles) : 1;
  localparam int unsigned NumStrips = IMAGE_HEIGHT / TILE_WIDTH;
  localparam int unsigned SW        = (NumStrips > 1) ? $clog2(NumStrips) : 1;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [TW-1:0]   y_q, y_d;
  logic [NW-1:0]   t_q, t_d;
  logic [TW-1:0]   r_q, r_d, c_q, c_d;
  logic [SW-1:0]   s_q, s_d;
  logic [1:0]      full_q, full_d;
  logic            wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic            valid_q, valid_d;
  logic            tile_start_q, tile_start_d;
  logic            tile_last_q, tile_last_d;
  logic            frame_last_q, frame_last_d;
  logic [7:0]      ram_rd_q;
  logic [7:0]      buf_mem [2**(AW+1)];

  logic            in_xfer, adv, issue, strip_done;
  logic            x_last, y_last, c_last, r_last, t_last, s_last;
  logic [AW-1:0]   wr_addr, rd_addr;

  assign oReady  = !full_q[wr_sel_q];
  assign in_xfer = iValid && oReady;
  // Read pipeline may move only when the output slot is empty or being consumed.
  assign adv     = !valid_q || iReady;

  assign x_last = (x_q == XW'(IMAGE_WIDTH - 1));
  assign y_last = (y_q == TW'(TILE_WIDTH - 1));
  assign c_last = (c_q == TW'(TILE_WIDTH - 1));
  assign r_last = (r_q == TW'(TILE_WIDTH - 1));
  assign t_last = (t_q == NW'(NumTiles - 1));
  assign s_last = (s_q == SW'(NumStrips - 1));

  assign wr_addr = AW'(IMAGE_WIDTH * 32'(y_q) + 32'(x_q));
  assign rd_addr = AW'(IMAGE_WIDTH * 32'(r_q) + TILE_WIDTH * 32'(t_q) + 32'(c_q));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    t_d          = t_q;
    r_d          = r_q;
    c_d          = c_q;
    s_d          = s_q;
    full_d       = full_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    valid_d      = valid_q;
    tile_start_d = tile_start_q;
    tile_last_d  = tile_last_q;
    frame_last_d = frame_last_q;
    issue        = 1'b0;
    strip_done   = 1'b0;

    if (in_xfer) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d              = '0;
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = ~wr_sel_q;
        end else begin
          y_d = y_q + TW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (full_q[rd_sel_q]) state_d = StDrain;
      end
      StDrain: begin
        issue = adv;
        if (issue) begin
          if (c_last) begin
            c_d = '0;
            if (r_last) begin
              r_d = '0;
              t_d = t_last ? '0 : t_q + NW'(1);
            end else begin
              r_d = r_q + TW'(1);
            end
          end else begin
            c_d = c_q + TW'(1);
          end
          if (c_last && r_last && t_last) begin
            strip_done       = 1'b1;
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            s_d              = s_last ? '0 : s_q + SW'(1);
            // Skip the idle bubble when the next strip is already waiting.
            state_d          = full_q[~rd_sel_q] ? StDrain : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (adv) begin
      valid_d      = issue;
      tile_start_d = issue && (r_q == '0) && (c_q == '0);
      tile_last_d  = issue && r_last && c_last;
      frame_last_d = strip_done && s_last;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      t_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      s_q          <= '0;
      full_q       <= '0;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      valid_q      <= 1'b0;
      tile_start_q <= 1'b0;
      tile_last_q  <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      t_q          <= t_d;
      r_q          <= r_d;
      c_q          <= c_d;
      s_q          <= s_d;
      full_q       <= full_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      valid_q      <= valid_d;
      tile_start_q <= tile_start_d;
      tile_last_q  <= tile_last_d;
      frame_last_q <= frame_last_d;
    end
  end

  // Strip RAM: buffer select is the address MSB; contents survive reset.
  always_ff @(posedge iClk) begin
    if (in_xfer) buf_mem[{wr_sel_q, wr_addr}] <= iData;
    if (issue)   ram_rd_q <= buf_mem[{rd_sel_q, rd_addr}];
  end

  assign oData      = valid_q ? ram_rd_q : 8'h00;
  assign oValid     = valid_q;
  assign oTileStart = tile_start_q;
  assign oTileLast  = tile_last_q;
  assign oFrameLast = frame_last_q;

endmodule
